hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
Sequential multiply/divide unit with its own architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU iteratively over multiple cycles.
- Performs MTHI/MTLO writes.
- Exposes HI/LO continuously for MFHI/MFLO.
- Sits beside the combinational ALU in the execute stage. The pipeline must stall any MFHI/MFLO or new mul/div while busy=1.

Parameters:
- WIDTH, 32, operand/HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request valid; sampled only when busy=0.
- op  in  4  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO (encodings in package).
- op_a  in  WIDTH  rs operand: multiplicand / dividend / MTHI-MTLO data.
- op_b  in  WIDTH  rt operand: multiplier / divisor.
- busy  out  1  high while a mul/div is in flight.
- done  out  1  one-cycle pulse when a mul/div result has been written to HI/LO.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Clocking and reset:
  - Single clock domain, clk. Reset is synchronous and active-high on reset.
  - At reset: hi=0, lo=0, busy=0, done=0, state=IDLE, iteration counter=0.
  - Reset asserted mid-operation aborts the operation. HI/LO go to 0 and no done pulse is produced.
- States: IDLE, RUN, FIXUP.
- IDLE:
  - start=1 with MULT/MULTU/DIV/DIVU at edge E0: latch |op_a|, |op_b| (magnitudes if signed op, raw if unsigned), latch result signs, counter=0, go to RUN.
  - start=1 with MTHI: hi<=op_a at E0. MTLO: lo<=op_a. Either way stay in IDLE, no busy, no done.
  - Undefined op codes are ignored.
- RUN:
  - One iteration per cycle.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract on a remainder/quotient pair.
  - After the iteration at counter=WIDTH-1 (edge E32), go to FIXUP.
- FIXUP (edge E33):
  - Apply sign correction and write hi/lo. Go to IDLE with done=1 for exactly one cycle.
  - busy=1 strictly after E0 until E33. New HI/LO are visible after E33. Latency is 33 cycles.
- Signed rules:
  - Product = two's complement of the 64-bit magnitude product if sign_a^sign_b. hi=[63:32], lo=[31:0].
  - Quotient truncates toward zero: negate if sign_a^sign_b. Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) -> lo=0x80000000, hi=0.
- Divide by zero (decided, not trapped):
  - Unsigned: lo=0xFFFFFFFF, hi=op_a.
  - Signed: lo=0xFFFFFFFF if op_a>=0 else 0x00000001; hi=op_a.
  - Latency is unchanged.
- start while busy=1 is ignored, including MTHI/MTLO. The requester must hold or retry.
- hi/lo keep their old values during RUN. They are updated only in FIXUP or by MTHI/MTLO.
- done and start may coincide in the same cycle. A new op is accepted because the state is already IDLE.

Decomposition:
- Shared package muldiv_pkg holds:
  - enum muldiv_op_t (4-bit): MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5.
  - enum muldiv_state_t: IDLE, RUN, FIXUP.
  - Localparam MULDIV_LATENCY=WIDTH+1.
- One sub-module, muldiv_iter_core:
  - Holds the accumulator/remainder datapath and performs one iteration per enable.
  - The top level owns the FSM, sign handling and HI/LO registers.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 cycles: hi=0xFFFFFFFE, lo=0x00000001, done pulse 1 cycle, busy high exactly 33 cycles.
- MULT -7 x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 7 -> lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5. DIV -5 / 0 -> lo=1, hi=0xFFFFFFFB.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 in consecutive idle cycles -> hi/lo updated next edge, busy/done stay 0. MTHI issued during RUN -> ignored, hi unchanged.
- Start DIVU, assert reset at iteration 10 -> hi=lo=0, busy=0, no done. A following MULTU 6 x 7 -> lo=42, hi=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH   = 32;
  localparam int unsigned MULDIV_LATENCY = MULDIV_WIDTH + 1;

  typedef enum logic [3:0] {
    MULT  = 4'd0,
    MULTU = 4'd1,
    DIV   = 4'd2,
    DIVU  = 4'd3,
    MTHI  = 4'd4,
    MTLO  = 4'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide, one step per i_step.
module muldiv_iter_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_is_div,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_is_div;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH+1:0]   w_trial;
  logic               w_fits;
  logic [2*WIDTH-1:0] w_acc_nxt;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  // Divide: acc = {remainder, dividend/quotient}, shifted left each step; an extra
  // borrow bit is kept because the shifted remainder can exceed WIDTH bits.
  always_comb begin
    w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
    w_trial   = {1'b0, r_acc[2*WIDTH-1:WIDTH-1]} - {2'b00, r_opnd};
    w_fits    = ~w_trial[WIDTH+1];
    w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
    if (r_is_div) begin
      if (w_fits) begin
        w_acc_nxt = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_nxt = {r_acc[2*WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
    end else if (i_load) begin
      r_is_div <= i_is_div;
      if (i_is_div) begin
        r_acc  <= {{WIDTH{1'b0}}, i_a};
        r_opnd <= i_b;
      end else begin
        r_acc  <= {{WIDTH{1'b0}}, i_b};
        r_opnd <= i_a;
      end
    end else if (i_step) begin
      r_acc <= w_acc_nxt;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  muldiv_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_count;
  logic               r_neg_q, r_neg_r, r_is_div, r_done;
  logic [WIDTH-1:0]   r_hi, r_lo;

  logic               w_is_muldiv, w_is_signed, w_is_div;
  logic               w_sign_a, w_sign_b;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic               w_load, w_step, w_fixup, w_last;
  logic [2*WIDTH-1:0] w_acc, w_prod;
  logic [WIDTH-1:0]   w_quot, w_rem;

  always_comb begin
    w_is_muldiv = 1'b0;
    w_is_signed = 1'b0;
    w_is_div    = 1'b0;
    case (op)
      MULT:  begin w_is_muldiv = 1'b1; w_is_signed = 1'b1; end
      MULTU: begin w_is_muldiv = 1'b1; end
      DIV:   begin w_is_muldiv = 1'b1; w_is_signed = 1'b1; w_is_div = 1'b1; end
      DIVU:  begin w_is_muldiv = 1'b1; w_is_div = 1'b1; end
      default: ;
    endcase
  end

  assign w_sign_a = w_is_signed & op_a[WIDTH-1];
  assign w_sign_b = w_is_signed & op_b[WIDTH-1];
  assign w_mag_a  = w_sign_a ? -op_a : op_a;
  assign w_mag_b  = w_sign_b ? -op_b : op_b;
  assign w_last   = (r_count == CNT_W'(WIDTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_fixup     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start && w_is_muldiv) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) w_state_nxt = FIXUP;
      end
      FIXUP: begin
        w_fixup     = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_div <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_fixup;
      if (w_load) begin
        r_count  <= '0;
        r_neg_q  <= w_sign_a ^ w_sign_b;
        r_neg_r  <= w_sign_a;
        r_is_div <= w_is_div;
      end else if (w_step) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  muldiv_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_is_div(w_is_div),
    .i_a     (w_mag_a),
    .i_b     (w_mag_b),
    .o_acc   (w_acc)
  );

  // A zero divisor makes every restoring step succeed, so the magnitude quotient
  // is all ones and the remainder equals |dividend|; sign fixup then yields the
  // defined divide-by-zero results without a special case.
  assign w_prod = r_neg_q ? -w_acc : w_acc;
  assign w_quot = r_neg_q ? -w_acc[WIDTH-1:0] : w_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -w_acc[2*WIDTH-1:WIDTH] : w_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_fixup) begin
      if (r_is_div) begin
        r_hi <= w_rem;
        r_lo <= w_quot;
      end else begin
        r_hi <= w_prod[2*WIDTH-1:WIDTH];
        r_lo <= w_prod[WIDTH-1:0];
      end
    end else if (r_state == IDLE && start) begin
      if (op == MTHI) r_hi <= op_a;
      if (op == MTLO) r_lo <= op_a;
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit with hand-computed HI/LO results.
module tb_hilo_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .op_a (op_a),
    .op_b (op_b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues the op, then returns at the negedge where done is high.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    start = 1'b1; op = o; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_low_while_busy"}, 64'(done), 64'd0);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(n), 64'(MULDIV_LATENCY));
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    int n;
    int done_seen;
    reset = 1'b1; start = 1'b0; op = 4'd0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back ops: each new start coincides with the previous done pulse.
    run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_m7x3", MULT,  32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("mult_m2xm3", MULT, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006);
    run_op("div_m7d2", DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_7dm2", DIV,    32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu_100d7", DIVU, 32'd100,      32'd7,        32'd2,        32'd14);
    run_op("div_minneg", DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("divu_5d0", DIVU,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF);
    run_op("div_m5d0", DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'h00000001);

    // MTHI then MTLO in consecutive idle cycles.
    start = 1'b1; op = MTHI; op_a = 32'h12345678;
    @(negedge clk);
    check("done_pulse_width", 64'(done), 64'd0);
    check("mthi_hi", 64'(hi), 64'h12345678);
    check("mthi_busy", 64'(busy), 64'd0);
    op = MTLO; op_a = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h9ABCDEF0);
    check("mtlo_hi_kept", 64'(hi), 64'h12345678);
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mtlo_done", 64'(done), 64'd0);

    // Undefined op code is ignored.
    start = 1'b1; op = 4'hF; op_a = 32'h11111111;
    @(negedge clk);
    start = 1'b0;
    check("undef_busy", 64'(busy), 64'd0);
    check("undef_hi", 64'(hi), 64'h12345678);
    check("undef_lo", 64'(lo), 64'h9ABCDEF0);

    // MTHI issued during RUN is dropped; HI/LO hold until fixup.
    start = 1'b1; op = DIVU; op_a = 32'd100; op_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = MTHI; op_a = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    check("mthi_run_busy", 64'(busy), 64'd1);
    check("mthi_run_hi", 64'(hi), 64'h12345678);
    check("run_lo_kept", 64'(lo), 64'h9ABCDEF0);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mthi_run_done", 64'(done), 64'd1);
    check("mthi_run_res_hi", 64'(hi), 64'd2);
    check("mthi_run_res_lo", 64'(lo), 64'd14);
    @(negedge clk);

    // Reset during iteration 10 aborts with no done pulse.
    start = 1'b1; op = DIVU; op_a = 32'd1000; op_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(done_seen), 64'd0);

    run_op("multu_6x7", MULTU, 32'd6, 32'd7, 32'd0, 32'd42);
    @(negedge clk);
    check("final_done_low", 64'(done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
